// File: rtl/bus_pkg.sv
// Shared types and helpers for the broadcast bus arbiter.
// Contents: FSM state enum, destination-ID width, broadcast ID,
//           and dest_of() to extract the destination ID from a packet word.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    WAIT,
    DELIVER
  } state_e;

  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;

  // Widest packet dest_of() accepts; callers zero-extend narrower words.
  localparam int MAX_W = 64;

  // Destination ID is the top ID_W bits of a width-bit packet.
  function automatic logic [ID_W-1:0] dest_of(input logic [MAX_W-1:0] word, input int width);
    return word[width-1 -: ID_W];
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bus between the per-device FIFO array and the arbiter.
// Ports: pndng/d_pop/pop on the source side, full/push/d_push on the
//        destination side; master = arbiter, slave = FIFO array.
interface bus_arbiter_if #(
  parameter int DEVICES = 4,
  parameter int WIDTH   = 16
);

  logic [DEVICES-1:0]            pndng;
  logic [DEVICES-1:0][WIDTH-1:0] d_pop;
  logic [DEVICES-1:0]            pop;
  logic [DEVICES-1:0]            full;
  logic [DEVICES-1:0]            push;
  logic [WIDTH-1:0]              d_push;

  modport master (
    input  pndng, d_pop, full,
    output pop, push, d_push
  );

  modport slave (
    output pndng, d_pop, full,
    input  pop, push, d_push
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority encoder.
// Ports: req (requests), last (previous winner) in; gnt (one-hot),
//        gnt_idx (winner index), any (some request present) out.
module rr_arbiter #(
  parameter int DEVICES = 4,
  localparam int IDX_W  = (DEVICES > 1) ? $clog2(DEVICES) : 1
) (
  input  logic [DEVICES-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [DEVICES-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  logic [IDX_W-1:0] idx;

  // Scan starts one past the last winner and wraps, so the last winner
  // is considered only after every other source.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int off = 1; off <= DEVICES; off++) begin
      idx = IDX_W'((int'(last) + off) % DEVICES);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter serialising packets from DEVICES source FIFOs onto one
// broadcast bus; unicast to dest ID, broadcast to all but the source.
// Ports: clk, reset (sync, active-high); bus (master modport); busy,
//        grant_id, drop_cnt (saturating invalid-destination drop count).
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int              DEVICES   = 4,
  parameter int              WIDTH     = 16,
  parameter logic [ID_W-1:0] BROADCAST = BROADCAST_ID,
  localparam int             IDX_W     = (DEVICES > 1) ? $clog2(DEVICES) : 1
) (
  input  logic                clk,
  input  logic                reset,
  bus_arbiter_if.master       bus,
  output logic                busy,
  output logic [3:0]          grant_id,
  output logic [15:0]         drop_cnt
);

  state_e             state;
  logic [IDX_W-1:0]   gnt_q;
  logic [IDX_W-1:0]   last_grant;
  logic [WIDTH-1:0]   pkt;
  logic [DEVICES-1:0] mask;
  logic [DEVICES-1:0] pop_q;
  logic [DEVICES-1:0] push_q;
  logic [WIDTH-1:0]   d_push_q;

  logic [DEVICES-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  logic [ID_W-1:0]    dest;
  logic [DEVICES-1:0] dest_mask;

  rr_arbiter #(.DEVICES(DEVICES)) u_rr (
    .req     (bus.pndng),
    .last    (last_grant),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  // Target mask for the head word of the granted source; an empty mask
  // marks the packet for dropping.
  always_comb begin
    dest      = dest_of(MAX_W'(bus.d_pop[gnt_q]), WIDTH);
    dest_mask = '0;
    if (int'(dest) < DEVICES) begin
      dest_mask[dest[IDX_W-1:0]] = 1'b1;
    end else if (dest == BROADCAST) begin
      dest_mask        = '1;
      dest_mask[gnt_q] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      gnt_q      <= '0;
      last_grant <= IDX_W'(DEVICES - 1);
      pkt        <= '0;
      mask       <= '0;
      pop_q      <= '0;
      push_q     <= '0;
      d_push_q   <= '0;
      busy       <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            gnt_q <= arb_idx;
            pop_q <= arb_gnt;
            busy  <= 1'b1;
            state <= POP;
          end
        end
        POP: begin
          pop_q <= '0;
          pkt   <= bus.d_pop[gnt_q];
          mask  <= dest_mask;
          state <= WAIT;
        end
        WAIT: begin
          if (mask == '0) begin
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            // A dropped packet still consumes the source's turn, so a source
            // emitting only bad packets cannot starve the others.
            last_grant <= gnt_q;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if ((mask & bus.full) == '0) begin
            // All targets must have room at once: no partial broadcast.
            push_q   <= mask;
            d_push_q <= pkt;
            state    <= DELIVER;
          end
        end
        DELIVER: begin
          push_q     <= '0;
          last_grant <= gnt_q;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pop    = pop_q;
  assign bus.push   = push_q;
  assign bus.d_push = d_push_q;
  assign grant_id   = 4'(gnt_q);

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: FWFT source FIFO model, directed
// vectors, and a scoreboard queue checked by an independent push monitor.
module tb_bus_arbiter;

  localparam int DEV = 4;
  localparam int W   = 16;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        busy;
  logic [3:0]  grant_id;
  logic [15:0] drop_cnt;

  bus_arbiter_if #(.DEVICES(DEV), .WIDTH(W)) bus ();

  bus_arbiter #(.DEVICES(DEV), .WIDTH(W), .BROADCAST(8'hFF)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.master),
    .busy     (busy),
    .grant_id (grant_id),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  // Source FIFO model: stimulus writes, the pop strobe advances the read side.
  logic [W-1:0] src_mem [DEV][32];
  logic [4:0]   wr_ptr  [DEV] = '{default: 5'd0};
  logic [4:0]   rd_ptr  [DEV] = '{default: 5'd0};

  for (genvar i = 0; i < DEV; i++) begin : g_src
    assign bus.pndng[i] = (wr_ptr[i] != rd_ptr[i]);
    assign bus.d_pop[i] = src_mem[i][rd_ptr[i]];
  end

  always @(posedge clk) begin
    for (int i = 0; i < DEV; i++)
      if (bus.pop[i]) rd_ptr[i] <= rd_ptr[i] + 5'd1;
  end

  int n_chk = 0;
  int n_err = 0;
  int push_cnt = 0;
  int pop_cnt = 0;
  logic [19:0] exp_q[$];
  logic [19:0] e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load(input int src, input logic [W-1:0] w, input logic [DEV-1:0] m, input bit exp_push);
    src_mem[src][wr_ptr[src]] = w;
    wr_ptr[src] = wr_ptr[src] + 5'd1;
    if (exp_push) exp_q.push_back({m, w});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    bus.full = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every push is matched against the next expected delivery.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.push != '0) begin
        push_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_push", {12'h0, bus.push, bus.d_push}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("push_mask", 32'(bus.push), 32'(e[19:16]));
          chk("push_data", 32'(bus.d_push), 32'(e[15:0]));
        end
      end
      if (bus.pop != '0) begin
        pop_cnt++;
        chk("pop_onehot", 32'($onehot(bus.pop)), 32'd1);
        chk("pop_push_overlap", 32'(bus.push), 32'd0);
      end
    end
  end

  int p0, c0, first;

  initial begin
    bus.full = '0;
    repeat (3) @(negedge clk);
    chk("rst_pop", 32'(bus.pop), 0);
    chk("rst_push", 32'(bus.push), 0);
    chk("rst_d_push", 32'(bus.d_push), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);
    reset = 1'b0;

    // Single unicast: pop in cycle 1, push in cycle 3.
    load(1, 16'h0201, 4'b0100, 1'b1);
    @(negedge clk);
    chk("t1_pop", 32'(bus.pop), 32'h2);
    chk("t1_busy_hi", 32'(busy), 1);
    chk("t1_grant_id", 32'(grant_id), 1);
    @(negedge clk);
    chk("t1_wait_pop", 32'(bus.pop), 0);
    chk("t1_wait_push", 32'(bus.push), 0);
    @(negedge clk);
    chk("t1_push", 32'(bus.push), 32'h4);
    chk("t1_d_push", 32'(bus.d_push), 32'h0201);
    @(negedge clk);
    chk("t1_busy_lo", 32'(busy), 0);
    chk("t1_push_lo", 32'(bus.push), 0);

    // Round robin: grant order 0,1,2,3 repeated, 12 packets in 48 cycles.
    do_reset();
    p0 = push_cnt;
    for (int k = 0; k < 3; k++)
      for (int s = 0; s < DEV; s++)
        load(s, {8'h00, 4'(s), 4'(k)}, 4'b0001, 1'b1);
    repeat (48) @(negedge clk);
    #1;
    chk("t2_push_count_48", 32'(push_cnt - p0), 12);
    repeat (4) @(negedge clk);
    #1;
    chk("t2_push_count_end", 32'(push_cnt - p0), 12);
    chk("t2_busy", 32'(busy), 0);

    // Broadcast from device 2: all but the source, single push cycle.
    p0 = push_cnt;
    load(2, 16'hFF55, 4'b1011, 1'b1);
    repeat (6) @(negedge clk);
    #1;
    chk("t3_push_count", 32'(push_cnt - p0), 1);

    // Destination full for 5 cycles delays the push by 5.
    p0 = push_cnt;
    c0 = pop_cnt;
    first = 0;
    bus.full = 4'b1000;
    load(0, 16'h0300, 4'b1000, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 7) bus.full = '0;
      if (bus.push != '0 && first == 0) first = c;
    end
    #1;
    chk("t4_push_cycle", 32'(first), 8);
    chk("t4_pop_count", 32'(pop_cnt - c0), 1);
    chk("t4_push_count", 32'(push_cnt - p0), 1);

    // Invalid destination: popped, dropped, counted.
    p0 = push_cnt;
    c0 = pop_cnt;
    load(0, 16'h0900, 4'b0000, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    chk("t5_drop_cnt", 32'(drop_cnt), 1);
    chk("t5_pop_count", 32'(pop_cnt - c0), 1);
    chk("t5_push_count", 32'(push_cnt - p0), 0);
    chk("t5_busy", 32'(busy), 0);

    // Reset while stalled in WAIT: latched packet is discarded.
    p0 = push_cnt;
    bus.full = 4'b0010;
    load(3, 16'h0100, 4'b0010, 1'b0);
    repeat (4) @(negedge clk);
    chk("t6_busy_in_wait", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_drop_cnt", 32'(drop_cnt), 0);
    chk("t6_rst_push", 32'(bus.push), 0);
    reset = 1'b0;
    bus.full = '0;
    repeat (6) @(negedge clk);
    #1;
    chk("t6_no_stale_push", 32'(push_cnt - p0), 0);
    load(0, 16'h0201, 4'b0100, 1'b1);
    load(3, 16'h0300, 4'b1000, 1'b1);
    @(negedge clk);
    chk("t6_first_grant", 32'(grant_id), 0);
    chk("t6_first_pop", 32'(bus.pop), 32'h1);
    repeat (10) @(negedge clk);
    #1;
    chk("t6_push_count", 32'(push_cnt - p0), 2);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
